// File: rtl/ic_mon_pkg.sv
// Shared definitions for the IC event monitor.
//   seq_state_e : Gray-walk detector states (IDLE, G00, G01, G11, G10)
//   Q00..Q10    : {q1,q0} state codes of the observed two-flip-flop stage
package ic_mon_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        G00  = 3'd1,
        G01  = 3'd2,
        G11  = 3'd3,
        G10  = 3'd4
    } seq_state_e;

    localparam logic [1:0] Q00 = 2'b00;
    localparam logic [1:0] Q01 = 2'b01;
    localparam logic [1:0] Q11 = 2'b11;
    localparam logic [1:0] Q10 = 2'b10;

endpackage

// File: rtl/ic_event_monitor_if.sv
// Event stream from the monitor to its consumer.
//   ev_data  : FIFO head, {q1,q0} captured at a y rising edge
//   ev_valid : FIFO non-empty
//   ev_ready : consumer accepts the head this cycle
//   ev_level : FIFO occupancy, 0..DEPTH
// master = monitor side, slave = consumer side.
interface ic_event_monitor_if #(
    parameter int DEPTH = 4
) ();
    localparam int LW = $clog2(DEPTH) + 1;

    logic [1:0]    ev_data;
    logic          ev_valid;
    logic          ev_ready;
    logic [LW-1:0] ev_level;

    modport master (
        output ev_data,
        output ev_valid,
        output ev_level,
        input  ev_ready
    );

    modport slave (
        input  ev_data,
        input  ev_valid,
        input  ev_level,
        output ev_ready
    );
endinterface

// File: rtl/ic_ev_fifo.sv
// DEPTH x 2-bit first-word-fall-through FIFO holding {q1,q0} event snapshots.
//   clk, rst_n   : clock, asynchronous active-low reset
//   push_i       : write push_data_i (accepted if not full, or full with a pop)
//   push_data_i  : {q1,q0} to store
//   pop_i        : consume head (ignored while empty)
//   head_o       : oldest entry, valid whenever empty_o=0
//   empty_o      : no entries
//   level_o      : occupancy = write count - read count
//   drop_o       : push requested but refused because full with no pop
module ic_ev_fifo #(
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [1:0]    push_data_i,
    input  logic          pop_i,
    output logic [1:0]    head_o,
    output logic          empty_o,
    output logic [LW-1:0] level_o,
    output logic          drop_o
);

    // Counters carry one extra bit so full and empty are distinguishable;
    // their low AW bits are the wrapping slot pointers.
    logic [LW-1:0] wr_cnt_q;
    logic [LW-1:0] rd_cnt_q;
    logic [1:0]    mem_q [DEPTH];
    logic          full;
    logic          do_push;
    logic          do_pop;

    assign level_o = wr_cnt_q - rd_cnt_q;
    assign empty_o = (level_o == '0);
    assign full    = (level_o == LW'(DEPTH));
    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the head slot, so a full FIFO still
    // accepts the push; the write lands in the slot being vacated.
    assign do_push = push_i && (!full || do_pop);
    assign drop_o  = push_i && !do_push;
    assign head_o  = mem_q[rd_cnt_q[AW-1:0]];

    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            // NOTE: storage is normally left unreset, but this array is tiny
            // and clearing it is what makes the head read back 0 in reset.
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_cnt_q[AW-1:0]] <= push_data_i;
                wr_cnt_q                <= wr_cnt_q + 1'b1;
            end
            if (do_pop) begin
                rd_cnt_q <= rd_cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ic_event_monitor.sv
// Monitor for a two-flip-flop IC stage. Samples {q1,q0,y} every clock,
// then one cycle later reports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   q0, q1, y    : observed IC state bits and output
//   clr          : synchronous clear of y_count and ev_overflow
//   y_count      : saturating count of sampled y=1 cycles
//   y_rise       : one-cycle pulse per sampled y rising edge
//   seq_match    : one-cycle pulse when the walk 00->01->11->10->00 completes
//   ev_overflow  : sticky, an event was dropped because the FIFO was full
//   ev           : event FIFO stream (data/valid/ready/level)
module ic_event_monitor
    import ic_mon_pkg::*;
#(
    parameter int CNT_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                q0,
    input  logic                q1,
    input  logic                y,
    input  logic                clr,
    output logic [CNT_W-1:0]    y_count,
    output logic                y_rise,
    output logic                seq_match,
    output logic                ev_overflow,
    ic_event_monitor_if.master  ev
);

    localparam int              LW      = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Sample stage
    logic [1:0]       samp_state_q;
    logic             samp_y_q;
    logic             samp_vld_q;   // sample registers hold a real capture, not reset
    logic             prev_y_q;     // y of the sample before samp_y_q

    // Registered results
    logic [CNT_W-1:0] y_count_q, y_count_d;
    logic             y_rise_q;
    logic             seq_match_q, seq_match_d;
    logic             ev_overflow_q, ev_overflow_d;
    seq_state_e       state_q, state_d;

    // FIFO hookup
    logic             rise_cond;
    logic             fifo_empty;
    logic             fifo_drop;
    logic [1:0]       fifo_head;
    logic [LW-1:0]    fifo_level;

    // prev_y resets to 0, so the first y=1 after reset counts as a rise.
    assign rise_cond = samp_vld_q && samp_y_q && !prev_y_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_state_q <= Q00;
            samp_y_q     <= 1'b0;
            samp_vld_q   <= 1'b0;
            prev_y_q     <= 1'b0;
        end else begin
            samp_state_q <= {q1, q0};
            samp_y_q     <= y;
            samp_vld_q   <= 1'b1;
            prev_y_q     <= samp_y_q;
        end
    end

    // NOTE: each always_comb output gets a default before any branch so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        y_count_d = y_count_q;
        if (clr) begin
            y_count_d = '0;
        end else if (samp_vld_q && samp_y_q && (y_count_q != CNT_MAX)) begin
            y_count_d = y_count_q + 1'b1;
        end
    end

    always_comb begin
        ev_overflow_d = ev_overflow_q | fifo_drop;
        if (clr) begin
            ev_overflow_d = 1'b0;
        end
    end

    // Gray-walk detector: one transition per sample; repeated samples hold.
    always_comb begin
        state_d     = state_q;
        seq_match_d = 1'b0;
        if (samp_vld_q) begin
            case (state_q)
                IDLE: begin
                    if (samp_state_q == Q00) state_d = G00;
                end
                G00: begin
                    if (samp_state_q == Q01)      state_d = G01;
                    else if (samp_state_q != Q00) state_d = IDLE;
                end
                G01: begin
                    if (samp_state_q == Q11)      state_d = G11;
                    else if (samp_state_q == Q00) state_d = G00;
                    else if (samp_state_q != Q01) state_d = IDLE;
                end
                G11: begin
                    if (samp_state_q == Q10)      state_d = G10;
                    else if (samp_state_q == Q00) state_d = G00;
                    else if (samp_state_q != Q11) state_d = IDLE;
                end
                G10: begin
                    if (samp_state_q == Q00) begin
                        state_d     = G00;
                        seq_match_d = 1'b1;
                    end else if (samp_state_q != Q10) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            y_count_q     <= '0;
            y_rise_q      <= 1'b0;
            seq_match_q   <= 1'b0;
            ev_overflow_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            y_count_q     <= y_count_d;
            y_rise_q      <= rise_cond;
            seq_match_q   <= seq_match_d;
            ev_overflow_q <= ev_overflow_d;
        end
    end

    ic_ev_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (rise_cond),
        .push_data_i (samp_state_q),
        .pop_i       (ev.ev_ready),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .level_o     (fifo_level),
        .drop_o      (fifo_drop)
    );

    assign y_count     = y_count_q;
    assign y_rise      = y_rise_q;
    assign seq_match   = seq_match_q;
    assign ev_overflow = ev_overflow_q;
    assign ev.ev_data  = fifo_head;
    assign ev.ev_valid = !fifo_empty;
    assign ev.ev_level = fifo_level;

endmodule

// File: tb/tb_ic_event_monitor.sv
// Directed bench for ic_event_monitor (CNT_W=4, DEPTH=4).
// Each table row gives the inputs presented before one rising edge and the
// outputs expected 1 time unit after that edge. Outputs after edge n reflect
// the sample captured at edge n-1 plus clr/ev_ready seen at edge n.
module tb_ic_event_monitor;

    localparam int CNT_W = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b1;
    logic             q0    = 1'b0;
    logic             q1    = 1'b0;
    logic             y     = 1'b0;
    logic             clr   = 1'b0;
    logic [CNT_W-1:0] y_count;
    logic             y_rise;
    logic             seq_match;
    logic             ev_overflow;

    ic_event_monitor_if #(.DEPTH(DEPTH)) ev_if ();

    ic_event_monitor #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .q0          (q0),
        .q1          (q1),
        .y           (y),
        .clr         (clr),
        .y_count     (y_count),
        .y_rise      (y_rise),
        .seq_match   (seq_match),
        .ev_overflow (ev_overflow),
        .ev          (ev_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] q;
        logic       y;
        logic       clr;
        logic       rdy;
        logic [3:0] cnt;
        logic       rise;
        logic       match;
        logic [2:0] lvl;
        logic       ov;
        logic [1:0] data;
    } vec_t;

    vec_t tbl[$];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Packs {cnt,rise,match,valid,level,ovf,data}; data only matters when valid.
    function automatic logic [31:0] pack(input logic [3:0] c, input logic r, input logic m,
                                         input logic v, input logic [2:0] l, input logic o,
                                         input logic [1:0] d);
        return {19'd0, c, r, m, v, l, o, (v ? d : 2'b00)};
    endfunction

    task automatic add(input logic [1:0] q, input logic yy, input logic c, input logic r,
                       input logic [3:0] cnt, input logic ri, input logic m,
                       input logic [2:0] lvl, input logic ov, input logic [1:0] d);
        vec_t v;
        v.q = q; v.y = yy; v.clr = c; v.rdy = r;
        v.cnt = cnt; v.rise = ri; v.match = m; v.lvl = lvl; v.ov = ov; v.data = d;
        tbl.push_back(v);
    endtask

    // Present inputs away from the edge, then sample outputs 1 unit after it.
    task automatic step(input logic [1:0] q, input logic yy, input logic c, input logic r);
        {q1, q0}       = q;
        y              = yy;
        clr            = c;
        ev_if.ev_ready = r;
        @(posedge clk);
        #1;
    endtask

    initial begin
        ev_if.ev_ready = 1'b0;

        //   q      y  clr rdy   cnt rise match lvl ov data
        // y pattern 0,1,1,0,1 with q 01,10,10,11,00; then drain 10, 00
        add(2'b01, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b10, 1, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b10, 1, 0, 0,   1, 1, 0, 1, 0, 2'b10);
        add(2'b11, 0, 0, 0,   2, 0, 0, 1, 0, 2'b10);
        add(2'b00, 1, 0, 0,   2, 0, 0, 1, 0, 2'b10);
        add(2'b00, 0, 0, 0,   3, 1, 0, 2, 0, 2'b10);
        add(2'b00, 0, 0, 1,   3, 0, 0, 1, 0, 2'b00);
        add(2'b00, 0, 0, 1,   3, 0, 0, 0, 0, 2'b00);
        add(2'b00, 0, 0, 1,   3, 0, 0, 0, 0, 2'b00);   // pop on empty ignored
        add(2'b00, 0, 1, 0,   0, 0, 0, 0, 0, 2'b00);   // clr count
        // walk 00,01,01,11,10,00 -> one match
        add(2'b01, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b01, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b11, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b10, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b00, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b00, 0, 0, 0,   0, 0, 1, 0, 0, 2'b00);
        // walk 00,01,10,00 -> no match
        add(2'b01, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b10, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b00, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b00, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        // walk 00,01,11,10,00,01,11,10,00 -> two matches
        add(2'b01, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b11, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b10, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b00, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b01, 0, 0, 0,   0, 0, 1, 0, 0, 2'b00);
        add(2'b11, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b10, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b00, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b00, 0, 0, 0,   0, 0, 1, 0, 0, 2'b00);
        add(2'b00, 0, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        // overflow: rises carrying 00,01,11,10,01 with ev_ready=0
        add(2'b00, 1, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b00, 0, 0, 0,   1, 1, 0, 1, 0, 2'b00);
        add(2'b01, 1, 0, 0,   1, 0, 0, 1, 0, 2'b00);
        add(2'b01, 0, 0, 0,   2, 1, 0, 2, 0, 2'b00);
        add(2'b11, 1, 0, 0,   2, 0, 0, 2, 0, 2'b00);
        add(2'b11, 0, 0, 0,   3, 1, 0, 3, 0, 2'b00);
        add(2'b10, 1, 0, 0,   3, 0, 0, 3, 0, 2'b00);
        add(2'b10, 0, 0, 0,   4, 1, 0, 4, 0, 2'b00);
        add(2'b01, 1, 0, 0,   4, 0, 0, 4, 0, 2'b00);
        add(2'b01, 0, 0, 0,   5, 1, 0, 4, 1, 2'b00);   // fifth event dropped
        add(2'b00, 0, 0, 1,   5, 0, 0, 3, 1, 2'b01);
        add(2'b00, 0, 0, 1,   5, 0, 0, 2, 1, 2'b11);
        add(2'b00, 0, 0, 1,   5, 0, 0, 1, 1, 2'b10);
        add(2'b00, 0, 0, 1,   5, 0, 0, 0, 1, 2'b00);
        add(2'b00, 0, 1, 0,   0, 0, 0, 0, 0, 2'b00);   // clr drops overflow
        // full + push + pop on the same edge
        add(2'b01, 1, 0, 0,   0, 0, 0, 0, 0, 2'b00);
        add(2'b01, 0, 0, 0,   1, 1, 0, 1, 0, 2'b01);
        add(2'b10, 1, 0, 0,   1, 0, 0, 1, 0, 2'b01);
        add(2'b10, 0, 0, 0,   2, 1, 0, 2, 0, 2'b01);
        add(2'b11, 1, 0, 0,   2, 0, 0, 2, 0, 2'b01);
        add(2'b11, 0, 0, 0,   3, 1, 0, 3, 0, 2'b01);
        add(2'b00, 1, 0, 0,   3, 0, 0, 3, 0, 2'b01);
        add(2'b00, 0, 0, 0,   4, 1, 0, 4, 0, 2'b01);
        add(2'b10, 1, 0, 0,   4, 0, 0, 4, 0, 2'b01);
        add(2'b10, 0, 0, 1,   5, 1, 0, 4, 0, 2'b10);   // push 10 + pop 01
        add(2'b10, 0, 0, 0,   5, 0, 0, 4, 0, 2'b10);
        add(2'b00, 0, 0, 1,   5, 0, 0, 3, 0, 2'b11);
        add(2'b00, 0, 0, 1,   5, 0, 0, 2, 0, 2'b00);
        add(2'b00, 0, 0, 1,   5, 0, 0, 1, 0, 2'b10);   // new entry at tail
        add(2'b00, 0, 0, 1,   5, 0, 0, 0, 0, 2'b00);

        // Reset state, asserted asynchronously between edges
        #2 rst_n = 1'b0;
        #1;
        check("reset_state",
              {19'd0, y_count, y_rise, seq_match, ev_if.ev_valid, ev_if.ev_level, ev_overflow, ev_if.ev_data},
              32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[i]) begin
            step(tbl[i].q, tbl[i].y, tbl[i].clr, tbl[i].rdy);
            check($sformatf("row%0d {cnt,rise,match,valid,lvl,ovf,data}", i + 1),
                  pack(y_count, y_rise, seq_match, ev_if.ev_valid, ev_if.ev_level, ev_overflow, ev_if.ev_data),
                  pack(tbl[i].cnt, tbl[i].rise, tbl[i].match, (tbl[i].lvl != 3'd0),
                       tbl[i].lvl, tbl[i].ov, tbl[i].data));
        end

        // Saturation: y held high, count tops out at 15 and holds
        step(2'b00, 0, 1, 1);
        check("sat_clr", 32'(y_count), 32'd0);
        for (int i = 1; i <= 20; i++) begin
            step(2'b00, 1, 0, 1);
            check($sformatf("sat_cnt%0d", i), 32'(y_count), (i - 1 > 15) ? 32'd15 : 32'(i - 1));
        end
        step(2'b00, 1, 0, 1);
        check("sat_hold", 32'(y_count), 32'd15);
        step(2'b00, 1, 1, 1);
        check("sat_clr_wins", 32'(y_count), 32'd0);
        step(2'b00, 1, 0, 1);
        check("sat_after_clr", 32'(y_count), 32'd1);

        // Mid-operation reset with two entries queued and the walk in G11
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step(2'b00, 1, 0, 0);
        step(2'b01, 0, 0, 0);
        step(2'b11, 1, 0, 0);
        step(2'b11, 0, 0, 0);
        step(2'b11, 0, 0, 0);
        check("pre_rst_level", 32'(ev_if.ev_level), 32'd2);
        check("pre_rst_count", 32'(y_count), 32'd2);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_outputs",
              {19'd0, y_count, y_rise, seq_match, ev_if.ev_valid, ev_if.ev_level, ev_overflow, ev_if.ev_data},
              32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // A detector left in G11 would fire on 10 then 00.
        step(2'b10, 0, 0, 0);
        step(2'b00, 0, 0, 0);
        step(2'b00, 0, 0, 0);
        check("postrst_no_match_a", {30'd0, seq_match, ev_if.ev_valid}, 32'd0);
        step(2'b00, 0, 0, 0);
        check("postrst_no_match_b", {30'd0, seq_match, ev_if.ev_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
